logic_issue_ctrl: RTL and testbench

LOGIC_ISSUE_CTRL -- requirements
Module: logic_issue_ctrl

---
 rtl/logic_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_logic_issue_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/logic_issue_ctrl.sv
// logic_issue_ctrl: issues one logic operation at a time to an external
// combinational logical unit and holds the captured result until the
// consumer takes it.
// Optional build macro: LOGIC_ISSUE_ERR_EN enables flagging of opcodes
// that are not AND/OR/XOR/NOT on res_err; without it res_err is tied low.
//
// state | meaning
// IDLE  | ready for a new operation
// EXEC  | operands registered, logical unit result settling
// DONE  | result captured and offered downstream

package constants;
  localparam int WORD_SIZE = 19;
endpackage

package opcodes;
  localparam logic [4:0] AND = 5'd4;
  localparam logic [4:0] OR  = 5'd5;
  localparam logic [4:0] XOR = 5'd6;
  localparam logic [4:0] NOT = 5'd7;
endpackage

module logic_issue_ctrl
  import constants::*;
  import opcodes::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [4:0]           instr_opcode,
  input  logic [WORD_SIZE-1:0] instr_a,
  input  logic [WORD_SIZE-1:0] instr_b,
  output logic [4:0]           lu_opcode,
  output logic [WORD_SIZE-1:0] lu_operand_1,
  output logic [WORD_SIZE-1:0] lu_operand_2,
  input  logic [WORD_SIZE-1:0] lu_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] res_data,
  output logic                 res_zero,
  output logic                 res_err,
  output logic [15:0]          done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [4:0]           op_q;
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic                 accept;
  logic                 retire;

  // State register; reset returns to IDLE so res_valid drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: state_next = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture; NOT is unary so its second operand is forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= instr_opcode;
      a_q  <= instr_a;
      b_q  <= (instr_opcode == NOT) ? '0 : instr_b;
    end
  end

  assign lu_opcode    = op_q;
  assign lu_operand_1 = a_q;
  assign lu_operand_2 = b_q;

  // Result capture at the end of the single EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_zero <= 1'b0;
    end else if (state == EXEC) begin
      res_data <= lu_out;
      res_zero <= (lu_out == '0);
    end
  end

`ifdef LOGIC_ISSUE_ERR_EN
  logic is_logic_op;
  assign is_logic_op = (op_q == AND) || (op_q == OR) || (op_q == XOR) || (op_q == NOT);

  // Error flag captured alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 res_err <= 1'b0;
    else if (state == EXEC)  res_err <= ~is_logic_op;
  end
`else
  assign res_err = 1'b0;
`endif

  // Saturating count of results taken downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                done_count <= '0;
    else if (retire && done_count != 16'hFFFF) done_count <= done_count + 16'd1;
  end

endmodule

// File: tb/tb_logic_issue_ctrl.sv
// Self-checking bench for logic_issue_ctrl: directed cases followed by
// randomized operations, checked against an operation-level model.
module tb_logic_issue_ctrl;
  import constants::*;
  import opcodes::*;

  localparam int W = WORD_SIZE;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [4:0]   instr_opcode;
  logic [W-1:0] instr_a;
  logic [W-1:0] instr_b;
  logic [4:0]   lu_opcode;
  logic [W-1:0] lu_operand_1;
  logic [W-1:0] lu_operand_2;
  logic [W-1:0] lu_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_zero;
  logic         res_err;
  logic [15:0]  done_count;

  int           checks = 0;
  int           errors = 0;
  logic [15:0]  exp_count = 16'd0;

  logic_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_a(instr_a), .instr_b(instr_b),
    .lu_opcode(lu_opcode), .lu_operand_1(lu_operand_1), .lu_operand_2(lu_operand_2),
    .lu_out(lu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_err(res_err), .done_count(done_count)
  );

  always #5 clk = ~clk;

  // Environment: the combinational logical unit the controller drives.
  always_comb begin
    lu_out = '0;
    case (lu_opcode)
      AND:     lu_out = lu_operand_1 & lu_operand_2;
      OR:      lu_out = lu_operand_1 | lu_operand_2;
      XOR:     lu_out = lu_operand_1 ^ lu_operand_2;
      NOT:     lu_out = ~lu_operand_1;
      default: lu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == AND) return a & b;
    if (op == OR)  return a | b;
    if (op == XOR) return a ^ b;
    if (op == NOT) return ~a;
    return '0;
  endfunction

  function automatic logic ref_err(input logic [4:0] op);
`ifdef LOGIC_ISSUE_ERR_EN
    return !(op == AND || op == OR || op == XOR || op == NOT);
`else
    return 1'b0;
`endif
  endfunction

  // One complete operation; entered and left at 1 time unit after an edge, DUT idle.
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] r;
    r = ref_result(op, a, b);
    check("idle_ready", instr_ready, 1);
    instr_valid = 1'b1; instr_opcode = op; instr_a = a; instr_b = b;
    @(posedge clk); #1;
    instr_valid  = 1'($urandom_range(0, 1));
    instr_opcode = 5'($urandom);
    instr_a      = W'($urandom);
    instr_b      = W'($urandom);
    check("exec_valid", res_valid, 0);
    check("exec_ready", instr_ready, 0);
    check("lu_opcode", lu_opcode, op);
    check("lu_op1", lu_operand_1, a);
    check("lu_op2", lu_operand_2, (op == NOT) ? '0 : b);
    @(posedge clk); #1;
    check("done_valid", res_valid, 1);
    check("res_data", res_data, r);
    check("res_zero", res_zero, (r == '0));
    check("res_err", res_err, ref_err(op));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, r);
      check("hold_ready", instr_ready, 0);
      check("hold_count", done_count, exp_count);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; instr_valid = 1'b0;
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    check("ret_valid", res_valid, 0);
    check("ret_ready", instr_ready, 1);
    check("ret_count", done_count, exp_count);
    check("ret_ignored", lu_operand_1, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    logic [4:0] ops [4];
    ops[0] = AND; ops[1] = OR; ops[2] = XOR; ops[3] = NOT;

    rst = 1'b1; instr_valid = 1'b0; instr_opcode = '0; instr_a = '0; instr_b = '0; res_ready = 1'b0;
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_count", done_count, 0);
    check("rst_lu_op", lu_opcode, 0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    run_op(AND, 19'h7FFFF, 19'h0F0F0, 0);
    check("and_count", done_count, 1);
    run_op(NOT, 19'h7FFFF, 19'h12345, 0);
    run_op(XOR, 19'h55555, 19'h2AAAA, 5);
    run_op(5'h1F, 19'h1234, 19'h4321, 1);

    // Reset while a result is pending.
    instr_valid = 1'b1; instr_opcode = XOR; instr_a = 19'h00F0F; instr_b = 19'h0FFFF;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", res_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_valid", res_valid, 0);
    check("async_count", done_count, 0);
    check("async_ready", instr_ready, 1);
    check("async_data", res_data, 0);
    exp_count = 16'd0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(OR, 19'h40001, 19'h00010, 0);
    check("post_rst_count", done_count, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) op = 5'($urandom);
      else                           op = ops[$urandom_range(0, 3)];
      run_op(op, W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    // Preload the counter near its ceiling, then run past it.
    force dut.done_count = 16'hFFF0;
    #1;
    release dut.done_count;
    exp_count = 16'hFFF0;
    for (int n = 0; n < 20; n++) run_op(OR, W'($urandom), W'($urandom), 0);
    check("sat_count", done_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
